// File: rtl/lock_scheduler.sv
// lock_scheduler: sequencer for the canal lock chamber. Latches gondola requests
// from the outer (high) and inner (low) sides, arbitrates them round-robin and
// steps the chamber through adjust / open / admit / close / transfer / open /
// release / close while enforcing the gate and level interlocks.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   req_outer/inner     passage requests (single-cycle pulse is enough, latched)
//   lock_level          current chamber water level
//   gondola_entered     pulse: granted gondola fully inside (OPEN_E only)
//   gondola_exited      pulse: gondola left the chamber (OPEN_X only)
//   raise, lower        registered water commands
//   outer/inner_gate_open  registered gate commands (level, 1 = open)
//   grant_outer/inner   registered entry invitation, only with that gate open
//   busy                high whenever the sequencer is not idle
//   timeout_err         one-cycle pulse when an entry slot is abandoned
//
// All outputs are registered from the next state, so the interlocks hold by
// construction: gates open only in OPEN_E/OPEN_X, water moves only in
// PREP/TRANSFER, and every path out of an open state passes a settle state.
// rst is asserted asynchronously; its release is expected to be synchronised
// to clk upstream.
module lock_scheduler #(
  parameter int WATER_W       = 8,
  parameter int OUTER_LEVEL   = 73,
  parameter int INNER_LEVEL   = 49,
  parameter int LEVEL_TOL     = 3,
  parameter int GATE_CYCLES   = 4,
  parameter int ENTER_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_outer,
  input  logic               req_inner,
  input  logic [WATER_W-1:0] lock_level,
  input  logic               gondola_entered,
  input  logic               gondola_exited,
  output logic               raise,
  output logic               lower,
  output logic               outer_gate_open,
  output logic               inner_gate_open,
  output logic               grant_outer,
  output logic               grant_inner,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TMR_W = $clog2((ENTER_TIMEOUT > GATE_CYCLES) ? ENTER_TIMEOUT : GATE_CYCLES) + 1;
  localparam logic [TMR_W-1:0] ENTER_LAST = TMR_W'(ENTER_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GATE_LAST  = TMR_W'(GATE_CYCLES - 1);

  // One extra bit so level differences never wrap.
  localparam logic signed [WATER_W:0] OUTER_S = (WATER_W+1)'(OUTER_LEVEL);
  localparam logic signed [WATER_W:0] INNER_S = (WATER_W+1)'(INNER_LEVEL);
  localparam logic signed [WATER_W:0] TOL_S   = (WATER_W+1)'(LEVEL_TOL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_OPEN_E,
    S_CLOSE_E,
    S_TRANSFER,
    S_OPEN_X,
    S_CLOSE_X,
    S_CLOSE_ABORT
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic               r_pend_outer;
  logic               r_pend_inner;
  logic               r_last_outer;   // side served last; reset = inner
  logic               r_entry_outer;  // entry side of the current passage
  logic               r_raise;
  logic               r_lower;
  logic               r_outer_gate;
  logic               r_inner_gate;
  logic               r_grant_outer;
  logic               r_grant_inner;
  logic               r_busy;
  logic               r_timeout;

  state_t             w_next;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic               w_pend_outer_nxt;
  logic               w_pend_inner_nxt;
  logic               w_last_outer_nxt;
  logic               w_entry_outer_nxt;
  logic               w_timeout_d;
  logic               w_adjust;
  logic               w_tgt_outer;
  logic signed [WATER_W:0] w_target;
  logic signed [WATER_W:0] w_diff;
  logic               w_below;
  logic               w_above;
  logic               w_matched;

  // PREP aims at the entry side's level, TRANSFER at the exit side's.
  assign w_adjust    = (r_state == S_PREP) || (r_state == S_TRANSFER);
  assign w_tgt_outer = (r_state == S_PREP) ? r_entry_outer : !r_entry_outer;
  assign w_target    = w_tgt_outer ? OUTER_S : INNER_S;
  assign w_diff      = $signed({1'b0, lock_level}) - w_target;
  assign w_below     = w_diff < -TOL_S;
  assign w_above     = w_diff > TOL_S;
  assign w_matched   = !w_below && !w_above;

  always_comb begin
    w_next            = r_state;
    w_pend_outer_nxt  = r_pend_outer | req_outer;
    w_pend_inner_nxt  = r_pend_inner | req_inner;
    w_last_outer_nxt  = r_last_outer;
    w_entry_outer_nxt = r_entry_outer;
    w_timeout_d       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_outer || r_pend_inner) begin
          // Tie goes to the side not served last.
          w_entry_outer_nxt = r_pend_outer && !(r_pend_inner && r_last_outer);
          w_next            = S_PREP;
        end
      end
      S_PREP: begin
        if (w_matched) w_next = S_OPEN_E;
      end
      S_OPEN_E: begin
        // Entry beats a coinciding timeout; a same-cycle request re-latches.
        if (gondola_entered || (r_timer == ENTER_LAST)) begin
          if (r_entry_outer) w_pend_outer_nxt = req_outer;
          else               w_pend_inner_nxt = req_inner;
          w_last_outer_nxt = r_entry_outer;
          w_timeout_d      = !gondola_entered;
          w_next           = gondola_entered ? S_CLOSE_E : S_CLOSE_ABORT;
        end
      end
      S_CLOSE_E: begin
        if (r_timer == GATE_LAST) w_next = S_TRANSFER;
      end
      S_TRANSFER: begin
        if (w_matched) w_next = S_OPEN_X;
      end
      S_OPEN_X: begin
        if (gondola_exited) w_next = S_CLOSE_X;
      end
      S_CLOSE_X, S_CLOSE_ABORT: begin
        if (r_timer == GATE_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    w_timer_nxt = (w_next == r_state) ? r_timer + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_pend_outer  <= 1'b0;
      r_pend_inner  <= 1'b0;
      r_last_outer  <= 1'b0;
      r_entry_outer <= 1'b0;
      r_raise       <= 1'b0;
      r_lower       <= 1'b0;
      r_outer_gate  <= 1'b0;
      r_inner_gate  <= 1'b0;
      r_grant_outer <= 1'b0;
      r_grant_inner <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_timer       <= w_timer_nxt;
      r_pend_outer  <= w_pend_outer_nxt;
      r_pend_inner  <= w_pend_inner_nxt;
      r_last_outer  <= w_last_outer_nxt;
      r_entry_outer <= w_entry_outer_nxt;
      // Water only moves while staying in an adjust state; a match leaves it.
      r_raise       <= w_adjust && w_below;
      r_lower       <= w_adjust && w_above;
      r_outer_gate  <= ((w_next == S_OPEN_E) &&  w_entry_outer_nxt) ||
                       ((w_next == S_OPEN_X) && !w_entry_outer_nxt);
      r_inner_gate  <= ((w_next == S_OPEN_E) && !w_entry_outer_nxt) ||
                       ((w_next == S_OPEN_X) &&  w_entry_outer_nxt);
      r_grant_outer <= (w_next == S_OPEN_E) &&  w_entry_outer_nxt;
      r_grant_inner <= (w_next == S_OPEN_E) && !w_entry_outer_nxt;
      r_busy        <= (w_next != S_IDLE);
      r_timeout     <= w_timeout_d;
    end
  end

  assign raise           = r_raise;
  assign lower           = r_lower;
  assign outer_gate_open = r_outer_gate;
  assign inner_gate_open = r_inner_gate;
  assign grant_outer     = r_grant_outer;
  assign grant_inner     = r_grant_inner;
  assign busy            = r_busy;
  assign timeout_err     = r_timeout;

endmodule

// File: tb/tb_lock_scheduler.sv
// Bench for lock_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model and
// the chamber interlock rules. A simple chamber plant follows raise/lower.
module tb_lock_scheduler;

  localparam int OUT_L = 73;
  localparam int IN_L  = 49;
  localparam int TOL   = 3;
  localparam int GATE  = 4;
  localparam int ENTO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_outer = 1'b0;
  logic       req_inner = 1'b0;
  logic       gondola_entered = 1'b0;
  logic       gondola_exited = 1'b0;
  logic [7:0] lock_level = 8'd52;
  logic raise, lower, outer_gate_open, inner_gate_open;
  logic grant_outer, grant_inner, busy, timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lock_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .req_outer       (req_outer),
    .req_inner       (req_inner),
    .lock_level      (lock_level),
    .gondola_entered (gondola_entered),
    .gondola_exited  (gondola_exited),
    .raise           (raise),
    .lower           (lower),
    .outer_gate_open (outer_gate_open),
    .inner_gate_open (inner_gate_open),
    .grant_outer     (grant_outer),
    .grant_inner     (grant_inner),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_vec();
    return int'({raise, lower, outer_gate_open, inner_gate_open,
                 grant_outer, grant_inner, busy, timeout_err});
  endfunction

  // ---------------- behavioural model ----------------
  // A passage walks through phases; each phase either waits for a condition
  // or counts a fixed number of cycles. Expected outputs describe the cycle
  // after each clock edge.
  localparam int P_IDLE = 0, P_PREP = 1, P_OPEN_E = 2, P_CLOSE_E = 3;
  localparam int P_XFER = 4, P_OPEN_X = 5, P_CLOSE_X = 6, P_ABORT = 7;

  int m_phase = P_IDLE;
  int m_age   = 0;
  bit m_po = 0, m_pi = 0, m_last_outer = 0, m_e_outer = 0;
  bit e_raise = 0, e_lower = 0, e_og = 0, e_ig = 0;
  bit e_go = 0, e_gi = 0, e_busy = 0, e_terr = 0;
  int m_tgt, m_d, m_np;
  bit m_adj, m_match, m_npo, m_npi, m_terr;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_phase = P_IDLE; m_age = 0;
      m_po = 0; m_pi = 0; m_last_outer = 0; m_e_outer = 0;
      {e_raise, e_lower, e_og, e_ig, e_go, e_gi, e_busy, e_terr} = '0;
    end else begin
      m_adj   = (m_phase == P_PREP) || (m_phase == P_XFER);
      // PREP heads for the entry side, TRANSFER for the opposite side.
      if ((m_phase == P_PREP && m_e_outer) || (m_phase != P_PREP && !m_e_outer)) m_tgt = OUT_L;
      else m_tgt = IN_L;
      m_d     = int'(lock_level) - m_tgt;
      m_match = (m_d >= -TOL) && (m_d <= TOL);
      m_npo   = m_po | req_outer;
      m_npi   = m_pi | req_inner;
      m_np    = m_phase;
      m_terr  = 0;
      case (m_phase)
        P_IDLE: if (m_po || m_pi) begin
          if (m_po && m_pi) m_e_outer = !m_last_outer;
          else              m_e_outer = m_po;
          m_np = P_PREP;
        end
        P_PREP:    if (m_match) m_np = P_OPEN_E;
        P_OPEN_E:  if (gondola_entered || m_age == ENTO - 1) begin
          if (m_e_outer) m_npo = req_outer; else m_npi = req_inner;
          m_last_outer = m_e_outer;
          m_terr = !gondola_entered;
          m_np = gondola_entered ? P_CLOSE_E : P_ABORT;
        end
        P_CLOSE_E: if (m_age == GATE - 1) m_np = P_XFER;
        P_XFER:    if (m_match) m_np = P_OPEN_X;
        P_OPEN_X:  if (gondola_exited) m_np = P_CLOSE_X;
        default:   if (m_age == GATE - 1) m_np = P_IDLE;
      endcase
      m_age   = (m_np == m_phase) ? m_age + 1 : 0;
      m_phase = m_np;
      m_po    = m_npo;
      m_pi    = m_npi;
      e_raise = m_adj && (m_d < -TOL);
      e_lower = m_adj && (m_d > TOL);
      e_terr  = m_terr;
      e_busy  = (m_phase != P_IDLE);
      e_go    = (m_phase == P_OPEN_E) && m_e_outer;
      e_gi    = (m_phase == P_OPEN_E) && !m_e_outer;
      e_og    = e_go || ((m_phase == P_OPEN_X) && !m_e_outer);
      e_ig    = e_gi || ((m_phase == P_OPEN_X) && m_e_outer);
    end
  end

  // ---------------- compare process ----------------
  int since_gate = 100;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("outputs_vs_model", dut_vec(),
            int'({e_raise, e_lower, e_og, e_ig, e_go, e_gi, e_busy, e_terr}));
      if (outer_gate_open || inner_gate_open) since_gate = 0;
      else if (since_gate < 100) since_gate++;
      check("both_gates_open", int'(outer_gate_open && inner_gate_open), 0);
      check("raise_and_lower", int'(raise && lower), 0);
      if (raise || lower) check("level_change_in_gate_settle", int'(since_gate > GATE), 1);
      if (grant_outer) check("grant_outer_gate_closed", int'(outer_gate_open), 1);
      if (grant_inner) check("grant_inner_gate_closed", int'(inner_gate_open), 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    req_outer = 0; req_inner = 0; gondola_entered = 0; gondola_exited = 0;
    if (raise && lock_level < 8'd255)      lock_level = lock_level + 8'd1;
    else if (lower && lock_level > 8'd0)   lock_level = lock_level - 8'd1;
  endtask

  task automatic wait_grant(output bit go, output bit gi);
    int n = 0;
    while (!(grant_outer || grant_inner) && n < 200) begin tick(); n++; end
    go = grant_outer; gi = grant_inner;
    if (!(go || gi)) check("grant_wait_expired", 0, 1);
  endtask

  task automatic run_auto(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      if (grant_outer || grant_inner) gondola_entered = 1;
      else if (outer_gate_open || inner_gate_open) gondola_exited = 1;
      tick();
      n++;
    end
    check("reach_idle", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit go, gi;
    int n;
    #1;
    check("reset_outputs", dut_vec(), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    tick();

    // Outer passage from level 52: raise to 70, then lower to 52.
    lock_level = 8'd52;
    req_outer = 1; tick();
    n = 0;
    while (!outer_gate_open && n < 100) begin tick(); n++; end
    check("outer_gate_opened", int'(outer_gate_open), 1);
    check("level_at_outer_open", int'(lock_level), 70);
    check("grant_outer_at_open", int'(grant_outer), 1);
    gondola_entered = 1; tick();
    check("outer_gate_closed_after_entry", int'(outer_gate_open), 0);
    n = 0;
    while (!inner_gate_open && n < 100) begin tick(); n++; end
    check("inner_gate_opened", int'(inner_gate_open), 1);
    check("level_at_inner_open", int'(lock_level), 52);
    check("no_grant_on_exit_gate", int'(grant_inner), 0);
    gondola_exited = 1; tick();
    check("inner_gate_closed_after_exit", int'(inner_gate_open), 0);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("close_x_cycles", n, GATE);

    // Already matched at 49: inner gate two cycles after the request.
    lock_level = 8'd49;
    tick();
    req_inner = 1; tick();
    tick();
    check("inner_gate_1_cycle", int'(inner_gate_open), 0);
    tick();
    check("inner_gate_2_cycles", int'(inner_gate_open), 1);
    check("no_water_when_matched", int'(raise || lower), 0);
    run_auto(300);

    // Round-robin: pair, second pair after outer entry, then third pair.
    lock_level = 8'd60;
    tick();
    req_outer = 1; req_inner = 1; tick();
    wait_grant(go, gi);
    check("rr_pair1_outer_first", int'(go), 1);
    gondola_entered = 1; tick();
    req_outer = 1; req_inner = 1; tick();
    run_auto(300);
    wait_grant(go, gi);
    check("rr_inner_second", int'(gi), 1);
    run_auto(300);
    wait_grant(go, gi);
    check("rr_outer_third", int'(go), 1);
    run_auto(300);
    req_outer = 1; req_inner = 1; tick();
    wait_grant(go, gi);
    check("rr_pair3_inner_first", int'(gi), 1);
    run_auto(300);
    wait_grant(go, gi);
    check("rr_pair3_outer_next", int'(go), 1);
    run_auto(300);

    // Entry timeout.
    lock_level = 8'd70;
    req_outer = 1; tick();
    wait_grant(go, gi);
    n = 0;
    while (!timeout_err && n < 40) begin tick(); n++; end
    check("timeout_latency", n, ENTO);
    check("timeout_gate_closed", int'(outer_gate_open), 0);
    check("timeout_grant_low", int'(grant_outer), 0);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("abort_settle_cycles", n, GATE);
    repeat (3) tick();
    check("timeout_pend_cleared", int'(busy), 0);

    // Reset in TRANSFER while raising.
    lock_level = 8'd49;
    req_inner = 1; tick();
    wait_grant(go, gi);
    gondola_entered = 1; tick();
    n = 0;
    while (!raise && n < 50) begin tick(); n++; end
    check("transfer_raising", int'(raise), 1);
    req_outer = 1; tick();
    #2 rst = 0;
    #1 check("async_reset_outputs", dut_vec(), 0);
    tick(); tick();
    rst = 1;
    repeat (5) tick();
    check("post_reset_idle", int'(busy), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_outer       = ($urandom_range(0, 9) == 0);
      req_inner       = ($urandom_range(0, 9) == 0);
      gondola_entered = ($urandom_range(0, 5) == 0);
      gondola_exited  = ($urandom_range(0, 3) == 0);
      if (!busy && $urandom_range(0, 19) == 0) lock_level = 8'($urandom_range(30, 100));
      tick();
    end
    run_auto(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_scheduler.md
Name: lock_scheduler

Overview:
- Sequencer for the canal lock chamber datapath.
- Collects gondola passage requests from the outer (high, level 73) and inner (low, level 49) sides and arbitrates them round-robin.
- Drives the chamber's raise/lower/gate-open controls through a fixed cycle: adjust level, open entry gate, admit, close, transfer level, open exit gate, release, close.
- Guarantees the interlocks (one gate at a time, no level change with a gate open) so the chamber datapath never sees an illegal command.

Parameters:
- WATER_W, 8, width of water-level buses.
- OUTER_LEVEL, 73, outer-side water level.
- INNER_LEVEL, 49, inner-side water level.
- LEVEL_TOL, 3, max |chamber - target| counted as "level matched".
- GATE_CYCLES, 4, settle cycles after any gate closes before any level change or next gate open.
- ENTER_TIMEOUT, 16, cycles a gondola may take to enter after grant before the slot is abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_outer  input  1  gondola waiting at outer side; a one-cycle pulse is sufficient (latched).
- req_inner  input  1  gondola waiting at inner side; latched as above.
- lock_level  input  WATER_W  current chamber water level.
- gondola_entered  input  1  pulse: granted gondola is fully inside the chamber.
- gondola_exited  input  1  pulse: gondola has left the chamber.
- raise  output  1  increase-water command to chamber.
- lower  output  1  decrease-water command to chamber.
- outer_gate_open  output  1  level command; 1 = outer gate open.
- inner_gate_open  output  1  level command; 1 = inner gate open.
- grant_outer  output  1  held high while outer gondola is invited to enter.
- grant_inner  output  1  held high while inner gondola is invited to enter.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse when an entry times out.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pend_outer=pend_inner=0, last_served=inner (so outer wins the first tie), timer=0. All outputs 0.
- Request latching: pend_x sets on req_x every cycle; clears only when that side's gondola_entered is accepted or its entry times out. A request arriving for the side currently being served is re-latched and served later.
- Level matched: |lock_level - target| <= LEVEL_TOL, computed with WATER_W+1 signed difference (no wrap).
- States:
  - IDLE: if neither pending, stay. If both pending, pick the side != last_served. Otherwise pick the pending side. Set entry side E and exit side X = opposite, then go to PREP. Decision takes 1 cycle after the request is visible.
  - PREP: target = level(E). raise=1 while lock_level < target-TOL; lower=1 while lock_level > target+TOL. When matched (raise/lower low that cycle) -> OPEN_E.
  - OPEN_E: E gate open; grant_E=1; timer counts. gondola_entered -> clear pend_E, last_served=E, go CLOSE_E. Timer == ENTER_TIMEOUT-1 with no entry -> timeout_err pulse, clear pend_E, last_served=E, go CLOSE_ABORT.
  - CLOSE_E: gate closed, grant low; wait GATE_CYCLES -> TRANSFER.
  - TRANSFER: target = level(X); raise/lower rules as in PREP. Matched -> OPEN_X.
  - OPEN_X: X gate open, no timeout. gondola_exited -> CLOSE_X.
  - CLOSE_X: wait GATE_CYCLES -> IDLE.
  - CLOSE_ABORT: wait GATE_CYCLES -> IDLE.
- Interlocks (registered outputs, must hold every cycle):
  - raise & lower never both 1.
  - No raise/lower while either gate open or during gate settle.
  - outer_gate_open & inner_gate_open never both 1.
  - grant_x only when gate_x open.
- Simultaneous events:
  - req and gondola_entered for the same side in one cycle -> pend stays set (the new request wins).
  - gondola_entered on the same cycle as the timeout -> entry wins, no error.
  - gondola_entered/exited outside OPEN_E/OPEN_X are ignored.
- Reset mid-operation: gates close, pending requests are lost, and the state returns to IDLE immediately.

Test Plan:
- Reset, lock_level=52, pulse req_outer -> PREP raises until level>=70, outer_gate_open=1, grant_outer=1; entered -> gate closes, 4 idle cycles, lower until <=52, inner_gate_open=1; exited -> IDLE after 4 cycles.
- req_outer and req_inner pulsed same cycle at reset -> outer served first, inner immediately after; third simultaneous pair -> inner first (round-robin).
- Grant with no gondola_entered -> timeout_err pulses exactly 16 cycles after grant rise, gate closes, pend cleared, busy drops after GATE_CYCLES.
- Check every cycle throughout random request/entry/exit traffic: no cycle with both gates open, raise&lower, or raise/lower with a gate open; no level change within 4 cycles of a gate closing.
- lock_level=49 already matched, req_inner -> inner gate opens 2 cycles after the request (IDLE decision, PREP match), with no raise/lower asserted.
- Drive rst low while in TRANSFER with raise=1 -> all outputs 0 asynchronously; after release, busy=0 and pending requests are cleared.
